// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID stage that fetches from a 1-cycle-latency ROM into a 2-entry skid FIFO
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_pc, i_ce                fetch address and chip enable from the PC register
//   o_pc_wd                   PC advance enable (fetch at i_pc issued this cycle)
//   o_rom_ce, o_rom_addr      instruction ROM request
//   i_rom_data                ROM read data, one cycle after o_rom_ce
//   i_stall, i_flush          decode backpressure and pipeline flush
//   o_id_pc, o_id_inst,
//   o_id_valid                instruction presented to decode
module if_id_stage #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_ce,
    output logic              o_pc_wd,
    output logic              o_rom_ce,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [INST_W-1:0] i_rom_data,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic [ADDR_W-1:0] o_id_pc,
    output logic [INST_W-1:0] o_id_inst,
    output logic              o_id_valid
);
    logic [ADDR_W+INST_W-1:0] r_mem [2];
    logic [1:0]               r_rd_ptr, r_wr_ptr;
    logic                     r_pending, r_discard;
    logic [ADDR_W-1:0]        r_req_pc;
    logic [ADDR_W-1:0]        r_id_pc;
    logic [INST_W-1:0]        r_id_inst;
    logic                     r_id_valid;

    logic [1:0]               w_count;
    logic                     w_arrival, w_leaving, w_push, w_pop;
    logic [2:0]               w_credits;
    logic [ADDR_W+INST_W-1:0] w_arr_data, w_head;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_arrival  = r_pending & ~r_discard;
    assign w_leaving  = ~i_stall & ((w_count != 2'd0) | w_arrival);
    // occupancy the FIFO could reach if this cycle issues a fetch: held + in flight - leaving
    assign w_credits  = {1'b0, w_count} + {2'b0, r_pending} - {2'b0, w_leaving};
    assign o_pc_wd    = i_rst_n & i_ce & ~i_flush & (w_credits < 3'd2);
    assign o_rom_ce   = o_pc_wd;
    assign o_rom_addr = i_pc;
    assign w_arr_data = {r_req_pc, i_rom_data};
    assign w_head     = r_mem[r_rd_ptr[0]];
    // an arrival is buffered unless it bypasses straight into an empty, unstalled stage
    assign w_push     = ~i_flush & w_arrival & (i_stall | (w_count != 2'd0));
    assign w_pop      = ~i_flush & ~i_stall & (w_count != 2'd0);
    assign o_id_pc    = r_id_pc;
    assign o_id_inst  = r_id_inst;
    assign o_id_valid = r_id_valid;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[0]] <= w_arr_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_pending  <= 1'b0;
            r_discard  <= 1'b0;
            r_req_pc   <= '0;
            r_id_pc    <= '0;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
        end else begin
            r_pending <= o_pc_wd;
            if (o_pc_wd) r_req_pc <= i_pc;
            r_discard <= i_flush & r_pending;
            if (i_flush) begin
                r_rd_ptr   <= r_wr_ptr;
                r_id_valid <= 1'b0;
                r_id_inst  <= NOP_INST;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
                if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
                if (!i_stall) begin
                    if (w_count != 2'd0) begin
                        {r_id_pc, r_id_inst} <= w_head;
                        r_id_valid           <= 1'b1;
                    end else if (w_arrival) begin
                        {r_id_pc, r_id_inst} <= w_arr_data;
                        r_id_valid           <= 1'b1;
                    end else begin
                        r_id_inst  <= NOP_INST;
                        r_id_valid <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed self-checking bench for if_id_stage
module tb_if_id_stage;
    logic        clk = 1'b0;
    logic        rst_n, ce, stall, flush;
    logic [31:0] pc;
    logic [31:0] rom_data = '0;
    logic        pc_wd, rom_ce, id_valid;
    logic [31:0] rom_addr, id_pc, id_inst;
    int          checks = 0;
    int          failures = 0;

    if_id_stage dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pc(pc), .i_ce(ce), .o_pc_wd(pc_wd),
        .o_rom_ce(rom_ce), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .i_stall(stall), .i_flush(flush), .o_id_pc(id_pc), .o_id_inst(id_inst),
        .o_id_valid(id_valid)
    );

    always #5 clk = ~clk;

    // PC register: advances by 4 whenever the stage accepts a fetch
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else if (pc_wd) pc <= pc + 32'd4;
    end

    // ROM whose word at each address equals the address, one-cycle latency
    always @(posedge clk) begin
        if (rom_ce) rom_data <= rom_addr;
    end

    // a buffered arrival while stalled must never land on a full FIFO
    always @(negedge clk) begin
        if (rst_n && stall && !flush && dut.r_pending && !dut.r_discard) begin
            checks++;
            if (dut.w_count === 2'd2) begin
                failures++;
                $display("FAIL full_push: count=%0d required <2", dut.w_count);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        ce = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ce = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #3;
        checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
            failures++;
            $display("FAIL reset_id: valid=%0b pc=%h inst=%h required 0/0/0", id_valid, id_pc, id_inst);
        end
        checks++;
        if (pc_wd !== 1'b0 || rom_ce !== 1'b0) begin
            failures++;
            $display("FAIL reset_req: pc_wd=%0b rom_ce=%0b required 0/0", pc_wd, rom_ce);
        end
    endtask

    task automatic test_stream;
        do_reset();
        checks++;
        if (pc_wd !== 1'b1 || rom_ce !== 1'b1 || rom_addr !== 32'h0) begin
            failures++;
            $display("FAIL stream_first_req: pc_wd=%0b rom_ce=%0b addr=%h required 1/1/0", pc_wd, rom_ce, rom_addr);
        end
        step();
        checks++;
        if (id_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_latency: valid=%0b required 0", id_valid);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) || id_inst !== 32'(4 * k) || pc_wd !== 1'b1) begin
                failures++;
                $display("FAIL stream_%0d: valid=%0b pc=%h inst=%h pc_wd=%0b required 1/%h/%h/1",
                         k, id_valid, id_pc, id_inst, pc_wd, 4 * k, 4 * k);
            end
        end
    endtask

    task automatic test_stall;
        do_reset();
        repeat (4) step();
        stall = 1'b1;
        #1;
        step();
        checks++;
        if (dut.w_count !== 2'd1 || id_pc !== 32'h8 || pc_wd !== 1'b0) begin
            failures++;
            $display("FAIL stall_c1: count=%0d pc=%h pc_wd=%0b required 1/8/0", dut.w_count, id_pc, pc_wd);
        end
        step();
        checks++;
        if (dut.w_count !== 2'd2 || id_pc !== 32'h8 || id_valid !== 1'b1 || pc_wd !== 1'b0) begin
            failures++;
            $display("FAIL stall_full: count=%0d pc=%h valid=%0b pc_wd=%0b required 2/8/1/0",
                     dut.w_count, id_pc, id_valid, pc_wd);
        end
        step();
        checks++;
        if (dut.w_count !== 2'd2 || id_pc !== 32'h8 || pc_wd !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold: count=%0d pc=%h pc_wd=%0b required 2/8/0", dut.w_count, id_pc, pc_wd);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (pc_wd !== 1'b1 || rom_addr !== 32'h14) begin
            failures++;
            $display("FAIL stall_release_req: pc_wd=%0b addr=%h required 1/14", pc_wd, rom_addr);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(12 + 4 * k) || id_inst !== 32'(12 + 4 * k)) begin
                failures++;
                $display("FAIL stall_resume_%0d: valid=%0b pc=%h inst=%h required 1/%h/%h",
                         k, id_valid, id_pc, id_inst, 12 + 4 * k, 12 + 4 * k);
            end
        end
    endtask

    task automatic test_flush;
        do_reset();
        repeat (5) step();
        flush = 1'b1;
        #1;
        checks++;
        if (pc_wd !== 1'b0 || id_pc !== 32'hC) begin
            failures++;
            $display("FAIL flush_req: pc_wd=%0b id_pc=%h required 0/c", pc_wd, id_pc);
        end
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b0 || id_inst !== 32'h0 || dut.w_count !== 2'd0) begin
            failures++;
            $display("FAIL flush_clear: valid=%0b inst=%h count=%0d required 0/0/0", id_valid, id_inst, dut.w_count);
        end
        step();
        checks++;
        if (id_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_dropped: valid=%0b pc=%h required valid 0", id_valid, id_pc);
        end
        step();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h14 || id_inst !== 32'h14) begin
            failures++;
            $display("FAIL flush_resume: valid=%0b pc=%h inst=%h required 1/14/14", id_valid, id_pc, id_inst);
        end
    endtask

    task automatic test_flush_stall;
        do_reset();
        repeat (4) step();
        stall = 1'b1;
        step();
        step();
        flush = 1'b1;
        #1;
        checks++;
        if (pc_wd !== 1'b0 || dut.w_count !== 2'd2) begin
            failures++;
            $display("FAIL fs_req: pc_wd=%0b count=%0d required 0/2", pc_wd, dut.w_count);
        end
        step();
        flush = 1'b0;
        stall = 1'b0;
        #1;
        checks++;
        if (dut.w_count !== 2'd0 || id_valid !== 1'b0 || id_inst !== 32'h0) begin
            failures++;
            $display("FAIL fs_clear: count=%0d valid=%0b inst=%h required 0/0/0", dut.w_count, id_valid, id_inst);
        end
        step();
        step();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h14) begin
            failures++;
            $display("FAIL fs_resume: valid=%0b pc=%h required 1/14", id_valid, id_pc);
        end
    endtask

    task automatic test_ce;
        do_reset();
        repeat (4) step();
        ce = 1'b0;
        #1;
        checks++;
        if (pc_wd !== 1'b0 || rom_ce !== 1'b0) begin
            failures++;
            $display("FAIL ce_off: pc_wd=%0b rom_ce=%0b required 0/0", pc_wd, rom_ce);
        end
        step();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'hC || rom_ce !== 1'b0) begin
            failures++;
            $display("FAIL ce_drain: valid=%0b pc=%h rom_ce=%0b required 1/c/0", id_valid, id_pc, rom_ce);
        end
        step();
        checks++;
        if (id_valid !== 1'b0) begin
            failures++;
            $display("FAIL ce_bubble: valid=%0b required 0", id_valid);
        end
        ce = 1'b1;
        #1;
        checks++;
        if (pc_wd !== 1'b1 || rom_addr !== 32'h10) begin
            failures++;
            $display("FAIL ce_resume_req: pc_wd=%0b addr=%h required 1/10", pc_wd, rom_addr);
        end
        step();
        step();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_inst !== 32'h10) begin
            failures++;
            $display("FAIL ce_resume: valid=%0b pc=%h inst=%h required 1/10/10", id_valid, id_pc, id_inst);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        repeat (4) step();
        stall = 1'b1;
        step();
        step();
        checks++;
        if (dut.w_count !== 2'd2) begin
            failures++;
            $display("FAIL ar_fill: count=%0d required 2", dut.w_count);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0 || dut.w_count !== 2'd0) begin
            failures++;
            $display("FAIL ar_state: valid=%0b pc=%h inst=%h count=%0d required 0/0/0/0",
                     id_valid, id_pc, id_inst, dut.w_count);
        end
        checks++;
        if (pc_wd !== 1'b0 || rom_ce !== 1'b0) begin
            failures++;
            $display("FAIL ar_req: pc_wd=%0b rom_ce=%0b required 0/0", pc_wd, rom_ce);
        end
        stall = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
            failures++;
            $display("FAIL ar_restart: valid=%0b pc=%h required 1/0", id_valid, id_pc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flush_stall();
        test_ce();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch / IF-ID pipeline stage directly downstream of the PC register.
- Issues instruction-ROM reads at the current PC and absorbs the ROM's one-cycle read latency.
- Buffers returned instructions in a 2-entry skid FIFO and presents {pc, inst, valid} to decode.
- Drives pc_wd back to the PC register as credit-based backpressure, so no fetched instruction is ever dropped under stall.

Parameters:
- ADDR_W, 32, instruction address width (matches InstAddrBus).
- INST_W, 32, instruction width.
- NOP_INST, 32'h00000000, value driven on id_inst when the stage holds no valid instruction.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  current fetch address from the PC register.
- ce  in  1  chip enable from the PC register; 0 means no fetching.
- pc_wd  out  1  advance enable to the PC register; 1 means the fetch at pc is issued this cycle.
- rom_ce  out  1  instruction ROM read enable.
- rom_addr  out  ADDR_W  instruction ROM address.
- rom_data  in  INST_W  ROM read data, valid exactly one cycle after rom_ce=1.
- stall  in  1  decode cannot accept; hold the id_* outputs.
- flush  in  1  discard all fetched and in-flight instructions.
- id_pc  out  ADDR_W  PC of the instruction presented to decode.
- id_inst  out  INST_W  instruction presented to decode.
- id_valid  out  1  id_pc/id_inst hold a real instruction.

Behaviour:
- Reset (rst=0, async):
  - FIFO count=0, pending=0, discard=0.
  - id_pc=0, id_inst=NOP_INST, id_valid=0.
  - pc_wd=0, rom_ce=0 while in reset.
- Request path (combinational): rom_ce=pc_wd; rom_addr=pc.
  - On a request, register pending<=1 and req_pc<=pc; otherwise pending<=0.
- arrival = pending & ~discard, sampled in the cycle after a request. The payload is {req_pc, rom_data}.
- leaving = ~stall & (count>0 | arrival).
- pc_wd = ce & ~flush & ((count + pending - leaving) < 2).
  - Credits never exceed FIFO depth 2.
  - Steady state with no stall gives 1 fetch per cycle.
- Decode register update when stall=0:
  - count>0: load the FIFO head and pop it. A simultaneous arrival is pushed.
  - count=0 and arrival: bypass, load the arrival directly into id_*.
  - Otherwise: bubble, id_valid<=0, id_inst<=NOP_INST, id_pc holds.
- stall=1: id_* hold; an arrival is pushed into the FIFO.
- Latency: pc issued in cycle t appears on id_* in cycle t+2 (bypass path, no stall).
- FIFO is 2 entries, circular read/write pointers with 1-bit wrap.
  - A push into a full FIFO cannot occur by construction; the bench asserts it.
  - Push and pop in the same cycle leave count unchanged.
- flush=1 (wins over stall):
  - FIFO cleared, id_valid<=0, id_inst<=NOP_INST.
  - discard<=pending, so a ROM word returning next cycle is dropped.
  - pc_wd=0 in the flush cycle.
- ce=0: pc_wd=0 and no new requests. Outstanding data still drains normally.
- Reset asserted mid-operation clears all state immediately; in-flight ROM data is ignored.
- Order is preserved: id_pc strictly follows fetch order; no duplicates, no drops except on flush.

Test Plan:
- Reset release, ce=1, ROM word = address, no stall -> id_valid rises 2 cycles after the first pc_wd. id_pc/id_inst are 0,4,8,C on consecutive cycles; pc_wd stays 1.
- stall held 3 cycles mid-stream at id_pc=8 -> FIFO fills to 2, pc_wd=0 while full, id_* hold 8. After release, id_pc continues C,10,14 with no gap or duplicate.
- flush in the cycle after the request for 0x10 -> next cycle id_valid=0 and id_inst=NOP_INST, 0x10 is never presented, count=0.
- flush and stall together with FIFO full -> flush wins: FIFO empty, id_valid=0, pc_wd=0 that cycle.
- ce=0 for 2 cycles -> rom_ce=0, pending data drains to id_*, then id_valid=0. Fetch resumes when ce returns to 1.
- rst asserted asynchronously between clock edges with count=2 -> outputs go to reset values immediately, before the next edge.
